fiber_bank_mc: RTL and testbench

- Next-generation FiberCache bank: set-associative, write-back, write-allocate.
- Implements all four FiberCache request types: FETCH, READ, WRITE, CONSUME.
- Victim choice: invalid ways first, then priority + SRRIP replacement; dirty victims are written back to DRAM.
- Sits between the PE crossbar and the DRAM crossbar, one bank per address slice; line size, sets, ways and metadata widths are all parametrised.

---
 rtl/fiber_bank_mc_if.sv | 35 +++
 rtl/fiber_bank_mc.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_fiber_bank_mc.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fiber_bank_mc_if.sv
// rtl/fiber_bank_mc_if.sv - PE request/response and DRAM writeback/fill handshakes of one FiberCache bank
interface fiber_bank_mc_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 128
);
    logic [3:0]            i_request_type;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_type_valid;
    logic                  o_type_ready;
    logic [DATA_WIDTH-1:0] o_data_o;
    logic                  o_data_o_valid;
    logic                  i_data_o_ready;
    logic [ADDR_WIDTH-1:0] o_dram_addr;
    logic [DATA_WIDTH-1:0] o_dram_data_o;
    logic                  o_dram_data_o_valid;
    logic                  i_dram_data_o_ready;
    logic [DATA_WIDTH-1:0] i_dram_data;
    logic                  i_dram_data_i_valid;
    logic                  o_dram_data_i_ready;

    modport slave (
        input  i_request_type, i_addr, i_data, i_type_valid, i_data_o_ready,
               i_dram_data_o_ready, i_dram_data, i_dram_data_i_valid,
        output o_type_ready, o_data_o, o_data_o_valid, o_dram_addr, o_dram_data_o,
               o_dram_data_o_valid, o_dram_data_i_ready
    );

    modport master (
        output i_request_type, i_addr, i_data, i_type_valid, i_data_o_ready,
               i_dram_data_o_ready, i_dram_data, i_dram_data_i_valid,
        input  o_type_ready, o_data_o, o_data_o_valid, o_dram_addr, o_dram_data_o,
               o_dram_data_o_valid, o_dram_data_i_ready
    );
endinterface

// File: rtl/fiber_bank_mc.sv
// rtl/fiber_bank_mc.sv - set-associative write-back FiberCache bank with priority + SRRIP replacement
module fiber_bank_mc #(
    parameter int LINE_BYTES    = 16,
    parameter int SETS          = 64,
    parameter int WAYS          = 4,
    parameter int ADDR_WIDTH    = 64,
    parameter int SRRIP_BITS    = 2,
    parameter int PRIORITY_BITS = 5
) (
    input  logic           i_clk,
    input  logic           i_nreset,
    fiber_bank_mc_if.slave io_bus
);
    localparam int DATA_WIDTH = 8 * LINE_BYTES;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int SET_W      = $clog2(SETS);
    localparam int LINE_W     = ADDR_WIDTH - OFF_W;
    localparam int TAG_W      = LINE_W - SET_W;
    localparam int WAY_W      = $clog2(WAYS);

    localparam logic [3:0] T_FETCH   = 4'b0001;
    localparam logic [3:0] T_READ    = 4'b0010;
    localparam logic [3:0] T_WRITE   = 4'b0100;
    localparam logic [3:0] T_CONSUME = 4'b1000;

    localparam logic [SRRIP_BITS-1:0]    RRPV_MAX = '1;
    localparam logic [SRRIP_BITS-1:0]    RRPV_INS = SRRIP_BITS'((1 << SRRIP_BITS) - 2);
    localparam logic [PRIORITY_BITS-1:0] PRIO_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

    logic [WAYS-1:0]          r_valid [SETS];
    logic [WAYS-1:0]          r_dirty [SETS];
    logic [TAG_W-1:0]         r_tag   [SETS][WAYS];
    logic [DATA_WIDTH-1:0]    r_data  [SETS][WAYS];
    logic [PRIORITY_BITS-1:0] r_prio  [SETS][WAYS];
    logic [SRRIP_BITS-1:0]    r_rrpv  [SETS][WAYS];

    state_t                   r_state;
    logic [3:0]               r_type;
    logic [LINE_W-1:0]        r_line;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [WAY_W-1:0]         r_way;
    logic                     r_consume;
    logic                     r_type_ready;
    logic [DATA_WIDTH-1:0]    r_resp_data;
    logic                     r_resp_valid;
    logic [ADDR_WIDTH-1:0]    r_dram_addr;
    logic [DATA_WIDTH-1:0]    r_dram_wdata;
    logic                     r_dram_wvalid;
    logic                     r_fill_ready;

    logic [SET_W-1:0]         w_set;
    logic [TAG_W-1:0]         w_tag;
    logic                     w_hit;
    logic [WAY_W-1:0]         w_hit_way;
    logic [WAY_W-1:0]         w_victim;
    logic                     w_victim_dirty;
    logic                     w_inv_found;
    logic                     w_best_found;
    logic [PRIORITY_BITS-1:0] w_min_prio;
    logic [SRRIP_BITS-1:0]    w_best_rrpv;

    logic                     w_alloc_en;
    logic [WAY_W-1:0]         w_alloc_way;
    logic [DATA_WIDTH-1:0]    w_alloc_data;
    logic                     w_alloc_dirty;
    logic [PRIORITY_BITS-1:0] w_alloc_prio;

    assign w_set = r_line[SET_W-1:0];
    assign w_tag = r_line[LINE_W-1:SET_W];

    // Victim: lowest invalid way, else min priority, then max rrpv, then lowest index.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_way    = '0;
        w_inv_found  = 1'b0;
        w_best_found = 1'b0;
        w_victim     = '0;
        w_min_prio   = PRIO_MAX;
        w_best_rrpv  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_set][w] && r_tag[w_set][w] == w_tag && !w_hit) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (r_prio[w_set][w] < w_min_prio) begin
                w_min_prio = r_prio[w_set][w];
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (r_prio[w_set][w] == w_min_prio &&
                (!w_best_found || r_rrpv[w_set][w] > w_best_rrpv)) begin
                w_best_found = 1'b1;
                w_best_rrpv  = r_rrpv[w_set][w];
                w_victim     = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_set][w]) begin
                w_inv_found = 1'b1;
                w_victim    = WAY_W'(w);
            end
        end
    end

    assign w_victim_dirty = r_valid[w_set][w_victim] && r_dirty[w_set][w_victim];

    // Line install: clean WRITE miss in LOOKUP, dirty WRITE miss after WB, FETCH/READ after FILL.
    always_comb begin
        w_alloc_en    = 1'b0;
        w_alloc_way   = r_way;
        w_alloc_data  = r_wdata;
        w_alloc_dirty = 1'b1;
        w_alloc_prio  = '0;
        case (r_state)
            S_LOOKUP: begin
                if (!w_hit && r_type == T_WRITE && !w_victim_dirty) begin
                    w_alloc_en  = 1'b1;
                    w_alloc_way = w_victim;
                end
            end
            S_WB: begin
                if (io_bus.i_dram_data_o_ready && r_type == T_WRITE) begin
                    w_alloc_en = 1'b1;
                end
            end
            S_FILL: begin
                if (io_bus.i_dram_data_i_valid && r_type != T_CONSUME) begin
                    w_alloc_en    = 1'b1;
                    w_alloc_data  = io_bus.i_dram_data;
                    w_alloc_dirty = 1'b0;
                    w_alloc_prio  = (r_type == T_FETCH) ? PRIORITY_BITS'(1) : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_prio[s][w] <= '0;
                    r_rrpv[s][w] <= '0;
                end
            end
            r_state       <= S_IDLE;
            r_type        <= '0;
            r_line        <= '0;
            r_wdata       <= '0;
            r_way         <= '0;
            r_consume     <= 1'b0;
            r_type_ready  <= 1'b1;
            r_resp_data   <= '0;
            r_resp_valid  <= 1'b0;
            r_dram_addr   <= '0;
            r_dram_wdata  <= '0;
            r_dram_wvalid <= 1'b0;
            r_fill_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.i_type_valid && $onehot(io_bus.i_request_type)) begin
                        r_type       <= io_bus.i_request_type;
                        r_line       <= io_bus.i_addr[ADDR_WIDTH-1:OFF_W];
                        r_wdata      <= io_bus.i_data;
                        r_type_ready <= 1'b0;
                        r_state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_consume <= 1'b0;
                    if (w_hit) begin
                        r_way <= w_hit_way;
                        case (r_type)
                            T_FETCH: begin
                                if (r_prio[w_set][w_hit_way] != PRIO_MAX) begin
                                    r_prio[w_set][w_hit_way] <= r_prio[w_set][w_hit_way] + 1'b1;
                                end
                                r_rrpv[w_set][w_hit_way] <= '0;
                                r_type_ready             <= 1'b1;
                                r_state                  <= S_IDLE;
                            end
                            T_READ: begin
                                if (r_prio[w_set][w_hit_way] != '0) begin
                                    r_prio[w_set][w_hit_way] <= r_prio[w_set][w_hit_way] - 1'b1;
                                end
                                r_rrpv[w_set][w_hit_way] <= '0;
                                r_resp_data              <= r_data[w_set][w_hit_way];
                                r_resp_valid             <= 1'b1;
                                r_state                  <= S_RESP;
                            end
                            T_WRITE: begin
                                r_data[w_set][w_hit_way]  <= r_wdata;
                                r_dirty[w_set][w_hit_way] <= 1'b1;
                                r_rrpv[w_set][w_hit_way]  <= '0;
                                r_type_ready              <= 1'b1;
                                r_state                   <= S_IDLE;
                            end
                            default: begin
                                r_resp_data  <= r_data[w_set][w_hit_way];
                                r_resp_valid <= 1'b1;
                                r_consume    <= 1'b1;
                                r_state      <= S_RESP;
                            end
                        endcase
                    end else if (r_type != T_CONSUME && w_victim_dirty) begin
                        r_way         <= w_victim;
                        r_dram_addr   <= {r_tag[w_set][w_victim], w_set, {OFF_W{1'b0}}};
                        r_dram_wdata  <= r_data[w_set][w_victim];
                        r_dram_wvalid <= 1'b1;
                        r_state       <= S_WB;
                    end else if (r_type == T_WRITE) begin
                        r_type_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        // CONSUME misses stream through without touching the set.
                        r_way        <= w_victim;
                        r_dram_addr  <= {r_line, {OFF_W{1'b0}}};
                        r_fill_ready <= 1'b1;
                        r_state      <= S_FILL;
                    end
                end
                S_WB: begin
                    if (io_bus.i_dram_data_o_ready) begin
                        r_dirty[w_set][r_way] <= 1'b0;
                        r_dram_wvalid         <= 1'b0;
                        r_dram_wdata          <= '0;
                        if (r_type == T_WRITE) begin
                            r_dram_addr  <= '0;
                            r_type_ready <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_dram_addr  <= {r_line, {OFF_W{1'b0}}};
                            r_fill_ready <= 1'b1;
                            r_state      <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (io_bus.i_dram_data_i_valid) begin
                        r_fill_ready <= 1'b0;
                        r_dram_addr  <= '0;
                        if (r_type == T_FETCH) begin
                            r_type_ready <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_resp_data  <= io_bus.i_dram_data;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (io_bus.i_data_o_ready) begin
                        if (r_consume) begin
                            r_valid[w_set][r_way] <= 1'b0;
                            r_dirty[w_set][r_way] <= 1'b0;
                        end
                        r_consume    <= 1'b0;
                        r_resp_valid <= 1'b0;
                        r_resp_data  <= '0;
                        r_type_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_type_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase

            if (w_alloc_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == w_alloc_way) begin
                        r_valid[w_set][w] <= 1'b1;
                        r_dirty[w_set][w] <= w_alloc_dirty;
                        r_tag[w_set][w]   <= w_tag;
                        r_data[w_set][w]  <= w_alloc_data;
                        r_prio[w_set][w]  <= w_alloc_prio;
                        r_rrpv[w_set][w]  <= RRPV_INS;
                    end else if (r_valid[w_set][w] && r_rrpv[w_set][w] != RRPV_MAX) begin
                        r_rrpv[w_set][w] <= r_rrpv[w_set][w] + 1'b1;
                    end
                end
            end
        end
    end

    assign io_bus.o_type_ready        = r_type_ready;
    assign io_bus.o_data_o            = r_resp_data;
    assign io_bus.o_data_o_valid      = r_resp_valid;
    assign io_bus.o_dram_addr         = r_dram_addr;
    assign io_bus.o_dram_data_o       = r_dram_wdata;
    assign io_bus.o_dram_data_o_valid = r_dram_wvalid;
    assign io_bus.o_dram_data_i_ready = r_fill_ready;
endmodule

// File: tb/tb_fiber_bank_mc.sv
// tb/tb_fiber_bank_mc.sv - randomized and directed bench for fiber_bank_mc against a transaction-level cache model
module tb_fiber_bank_mc;
    localparam logic [3:0] T_FETCH   = 4'b0001;
    localparam logic [3:0] T_READ    = 4'b0010;
    localparam logic [3:0] T_WRITE   = 4'b0100;
    localparam logic [3:0] T_CONSUME = 4'b1000;

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fiber_bank_mc_if #(.ADDR_WIDTH(64), .DATA_WIDTH(128)) bus ();

    fiber_bank_mc #(
        .LINE_BYTES(16), .SETS(64), .WAYS(4), .ADDR_WIDTH(64), .SRRIP_BITS(2), .PRIORITY_BITS(5)
    ) dut (
        .i_clk(clk),
        .i_nreset(nreset),
        .io_bus(bus)
    );

    // Cache model: one entry per (set, way), holding the full line address.
    bit           m_valid [64][4];
    bit           m_dirty [64][4];
    logic [63:0]  m_line  [64][4];
    logic [127:0] m_data  [64][4];
    int           m_prio  [64][4];
    int           m_rrpv  [64][4];

    bit           exp_hit, exp_wb, exp_fill, exp_resp;
    logic [63:0]  exp_wb_addr, exp_fill_addr;
    logic [127:0] exp_wb_data, exp_resp_data;
    bit           obs_wb, obs_fill, obs_resp;
    logic [63:0]  obs_wb_addr, obs_fill_addr;
    logic [127:0] obs_wb_data, obs_resp_data;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_prio[s][w]  = 0;
                m_rrpv[s][w]  = 0;
            end
        end
    endtask

    function automatic int model_victim(input int s);
        int minp, best;
        for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
        minp = m_prio[s][0];
        for (int w = 1; w < 4; w++) if (m_prio[s][w] < minp) minp = m_prio[s][w];
        best = -1;
        for (int w = 0; w < 4; w++) begin
            if (m_prio[s][w] == minp && (best < 0 || m_rrpv[s][w] > m_rrpv[s][best])) best = w;
        end
        return best;
    endfunction

    task automatic model_apply(input logic [3:0] t, input logic [63:0] a,
                               input logic [127:0] d, input logic [127:0] fill_d);
        int s, hw, v;
        logic [63:0] line;
        s    = int'((a >> 4) & 64'h3F);
        line = a & ~64'hF;
        hw   = -1;
        for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_line[s][w] == line) hw = w;
        exp_hit = (hw >= 0);
        exp_wb = 0; exp_fill = 0; exp_resp = 0;
        exp_wb_addr = '0; exp_wb_data = '0; exp_fill_addr = line; exp_resp_data = '0;
        if (t == T_CONSUME) begin
            exp_resp = 1;
            if (exp_hit) begin
                exp_resp_data = m_data[s][hw];
                m_valid[s][hw] = 0;
                m_dirty[s][hw] = 0;
            end else begin
                exp_fill = 1;
                exp_resp_data = fill_d;
            end
        end else if (exp_hit) begin
            m_rrpv[s][hw] = 0;
            if (t == T_FETCH) begin
                if (m_prio[s][hw] < 31) m_prio[s][hw]++;
            end else if (t == T_READ) begin
                if (m_prio[s][hw] > 0) m_prio[s][hw]--;
                exp_resp = 1;
                exp_resp_data = m_data[s][hw];
            end else begin
                m_data[s][hw]  = d;
                m_dirty[s][hw] = 1;
            end
        end else begin
            v = model_victim(s);
            if (m_valid[s][v] && m_dirty[s][v]) begin
                exp_wb = 1;
                exp_wb_addr = m_line[s][v];
                exp_wb_data = m_data[s][v];
            end
            for (int w = 0; w < 4; w++) begin
                if (w != v && m_valid[s][w] && m_rrpv[s][w] < 3) m_rrpv[s][w]++;
            end
            m_valid[s][v] = 1;
            m_line[s][v]  = line;
            m_rrpv[s][v]  = 2;
            if (t == T_WRITE) begin
                m_data[s][v] = d; m_dirty[s][v] = 1; m_prio[s][v] = 0;
            end else begin
                exp_fill = 1;
                m_data[s][v] = fill_d; m_dirty[s][v] = 0;
                m_prio[s][v] = (t == T_FETCH) ? 1 : 0;
                if (t == T_READ) begin
                    exp_resp = 1;
                    exp_resp_data = fill_d;
                end
            end
        end
    endtask

    // One request end to end: DRAM and response sides are serviced as the DUT asks.
    task automatic txn(input logic [3:0] t, input logic [63:0] a, input logic [127:0] d,
                       input logic [127:0] fill_d, input int wb_stall, input int resp_stall);
        int cyc, wbs, rss, resp_cyc, done_cyc;
        bit done;
        model_apply(t, a, d, fill_d);
        obs_wb = 0; obs_fill = 0; obs_resp = 0;
        obs_wb_addr = '0; obs_wb_data = '0; obs_fill_addr = '0; obs_resp_data = '0;
        wbs = 0; rss = 0; resp_cyc = -1; done_cyc = -1; done = 0;
        @(negedge clk);
        checks++;
        if (bus.o_type_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b expected 1", bus.o_type_ready);
        end
        bus.i_request_type = t; bus.i_addr = a; bus.i_data = d; bus.i_type_valid = 1'b1;
        @(posedge clk);
        cyc = 1;
        while (!done) begin
            @(negedge clk);
            bus.i_type_valid = 1'b0;
            if (bus.o_type_ready === 1'b1) begin
                done = 1;
                done_cyc = cyc;
            end else begin
                if (bus.o_dram_data_o_valid === 1'b1) begin
                    if (!obs_wb) begin
                        obs_wb_addr = bus.o_dram_addr;
                        obs_wb_data = bus.o_dram_data_o;
                    end
                    obs_wb = 1;
                    checks++;
                    if (bus.o_dram_addr !== exp_wb_addr || bus.o_dram_data_o !== exp_wb_data) begin
                        errors++;
                        $display("FAIL wb_out: got addr %h data %h expected addr %h data %h",
                                 bus.o_dram_addr, bus.o_dram_data_o, exp_wb_addr, exp_wb_data);
                    end
                    if (wbs < wb_stall) begin
                        wbs++;
                        bus.i_dram_data_o_ready = 1'b0;
                    end else bus.i_dram_data_o_ready = 1'b1;
                end else bus.i_dram_data_o_ready = 1'b0;
                if (bus.o_dram_data_i_ready === 1'b1) begin
                    obs_fill = 1;
                    obs_fill_addr = bus.o_dram_addr;
                    checks++;
                    if (bus.o_dram_addr !== exp_fill_addr) begin
                        errors++;
                        $display("FAIL fill_addr: got %h expected %h", bus.o_dram_addr, exp_fill_addr);
                    end
                    bus.i_dram_data = fill_d;
                    bus.i_dram_data_i_valid = 1'b1;
                end else bus.i_dram_data_i_valid = 1'b0;
                if (bus.o_data_o_valid === 1'b1) begin
                    if (!obs_resp) begin
                        resp_cyc = cyc;
                        obs_resp_data = bus.o_data_o;
                    end
                    obs_resp = 1;
                    checks++;
                    if (bus.o_data_o !== exp_resp_data) begin
                        errors++;
                        $display("FAIL resp_data: got %h expected %h", bus.o_data_o, exp_resp_data);
                    end
                    if (rss < resp_stall) begin
                        rss++;
                        bus.i_data_o_ready = 1'b0;
                    end else bus.i_data_o_ready = 1'b1;
                end else bus.i_data_o_ready = 1'b0;
                if (cyc >= 300) begin
                    errors++;
                    $display("FAIL txn_timeout: got busy after %0d cycles expected ready", cyc);
                    done = 1;
                end else begin
                    @(posedge clk);
                    cyc++;
                end
            end
        end
        bus.i_dram_data_o_ready = 1'b0; bus.i_dram_data_i_valid = 1'b0; bus.i_data_o_ready = 1'b0;
        checks++;
        if (obs_wb !== exp_wb || obs_fill !== exp_fill || obs_resp !== exp_resp) begin
            errors++;
            $display("FAIL txn_events: got wb %b fill %b resp %b expected wb %b fill %b resp %b (type %b addr %h)",
                     obs_wb, obs_fill, obs_resp, exp_wb, exp_fill, exp_resp, t, a);
        end
        checks++;
        if (bus.o_data_o !== 128'h0) begin
            errors++;
            $display("FAIL idle_data_o: got %h expected 0", bus.o_data_o);
        end
        if (exp_hit && exp_resp) begin
            checks++;
            if (resp_cyc != 2) begin
                errors++;
                $display("FAIL hit_resp_latency: got %0d expected 2", resp_cyc);
            end
        end else if (exp_hit) begin
            checks++;
            if (done_cyc != 2) begin
                errors++;
                $display("FAIL hit_ready_latency: got %0d expected 2", done_cyc);
            end
        end
    endtask

    task automatic test_reset();
        bus.i_request_type = '0; bus.i_addr = '0; bus.i_data = '0; bus.i_type_valid = 1'b0;
        bus.i_data_o_ready = 1'b0; bus.i_dram_data_o_ready = 1'b0;
        bus.i_dram_data = '0; bus.i_dram_data_i_valid = 1'b0;
        nreset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_type_ready !== 1'b1 || bus.o_data_o_valid !== 1'b0 || bus.o_dram_data_o_valid !== 1'b0 ||
            bus.o_dram_data_i_ready !== 1'b0 || bus.o_data_o !== '0 || bus.o_dram_addr !== '0 ||
            bus.o_dram_data_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy %b rv %b wv %b fr %b data %h addr %h wdata %h expected 1 0 0 0 0 0 0",
                     bus.o_type_ready, bus.o_data_o_valid, bus.o_dram_data_o_valid, bus.o_dram_data_i_ready,
                     bus.o_data_o, bus.o_dram_addr, bus.o_dram_data_o);
        end
        nreset = 1'b1;
    endtask

    task automatic test_read_miss_hit();
        logic [127:0] pat;
        pat = {8{16'hAAAA}};
        txn(T_READ, 64'h100, rand128(), pat, 0, 0);
        checks++;
        if (obs_fill_addr !== 64'h100 || obs_resp_data !== pat) begin
            errors++;
            $display("FAIL read_miss: got fill %h resp %h expected fill 100 resp %h", obs_fill_addr, obs_resp_data, pat);
        end
        txn(T_READ, 64'h100, rand128(), rand128(), 0, 0);
        checks++;
        if (obs_fill !== 1'b0 || obs_wb !== 1'b0 || obs_resp_data !== pat) begin
            errors++;
            $display("FAIL read_hit: got fill %b wb %b resp %h expected 0 0 %h", obs_fill, obs_wb, obs_resp_data, pat);
        end
    endtask

    task automatic test_nop();
        @(negedge clk);
        bus.i_request_type = 4'b0011; bus.i_addr = 64'h100; bus.i_type_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_type_valid = 1'b0;
        checks++;
        if (bus.o_type_ready !== 1'b1 || bus.o_dram_data_o_valid !== 1'b0 ||
            bus.o_dram_data_i_ready !== 1'b0 || bus.o_data_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL nop: got rdy %b wv %b fr %b rv %b expected 1 0 0 0", bus.o_type_ready,
                     bus.o_dram_data_o_valid, bus.o_dram_data_i_ready, bus.o_data_o_valid);
        end
        txn(T_READ, 64'h100, rand128(), rand128(), 0, 0);
    endtask

    task automatic test_resp_stall();
        txn(T_READ, 64'h100, rand128(), rand128(), 0, 5);
    endtask

    task automatic test_write_evict();
        logic [127:0] d [5];
        for (int i = 0; i < 5; i++) begin
            d[i] = rand128();
            txn(T_WRITE, 64'(i) * 64'h400, d[i], rand128(), 3, 0);
        end
        checks++;
        if (obs_wb !== 1'b1 || obs_wb_addr !== 64'h0 || obs_wb_data !== d[0]) begin
            errors++;
            $display("FAIL write_evict: got wb %b addr %h data %h expected 1 0 %h", obs_wb, obs_wb_addr, obs_wb_data, d[0]);
        end
    endtask

    task automatic test_fetch_priority();
        repeat (3) txn(T_FETCH, 64'h200, rand128(), rand128(), 0, 0);
        for (int k = 1; k <= 6; k++) txn(T_READ, 64'h200 + 64'(k) * 64'h400, rand128(), rand128(), 0, 0);
        txn(T_FETCH, 64'h200, rand128(), rand128(), 0, 0);
        checks++;
        if (obs_fill !== 1'b0) begin
            errors++;
            $display("FAIL fetch_priority: got fill %b expected 0", obs_fill);
        end
    endtask

    task automatic test_consume();
        logic [127:0] d;
        d = rand128();
        txn(T_WRITE, 64'h300, d, rand128(), 0, 0);
        txn(T_CONSUME, 64'h300, rand128(), rand128(), 0, 0);
        checks++;
        if (obs_wb !== 1'b0 || obs_resp_data !== d) begin
            errors++;
            $display("FAIL consume_hit: got wb %b resp %h expected 0 %h", obs_wb, obs_resp_data, d);
        end
        txn(T_READ, 64'h300, rand128(), rand128(), 0, 0);
        checks++;
        if (obs_fill !== 1'b1 || obs_fill_addr !== 64'h300) begin
            errors++;
            $display("FAIL consume_then_read: got fill %b addr %h expected 1 300", obs_fill, obs_fill_addr);
        end
    endtask

    task automatic test_random();
        int sets [3] = '{0, 5, 63};
        logic [63:0] a;
        logic [3:0]  t;
        int tg;
        for (int n = 0; n < 200; n++) begin
            tg = $urandom_range(0, 5);
            a  = (64'(tg) << 10) | (64'(sets[$urandom_range(0, 2)]) << 4) | 64'($urandom_range(0, 15));
            if (tg == 5) a = a | 64'hF000_0000_0000_0000;
            t  = 4'b0001 << $urandom_range(0, 3);
            txn(t, a, rand128(), rand128(), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_fill();
        int guard;
        bit seen;
        @(negedge clk);
        bus.i_request_type = T_READ; bus.i_addr = 64'h7700; bus.i_type_valid = 1'b1;
        @(posedge clk);
        seen = 0;
        guard = 0;
        while (!seen && guard < 20) begin
            @(negedge clk);
            bus.i_type_valid = 1'b0;
            bus.i_dram_data_o_ready = bus.o_dram_data_o_valid;
            if (bus.o_dram_data_i_ready === 1'b1) seen = 1;
            else begin
                guard++;
                @(posedge clk);
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_fill_reach: got no fill request expected one");
        end
        bus.i_dram_data_o_ready = 1'b0;
        nreset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_type_ready !== 1'b1 || bus.o_data_o_valid !== 1'b0 || bus.o_dram_data_o_valid !== 1'b0 ||
            bus.o_dram_data_i_ready !== 1'b0 || bus.o_data_o !== '0 || bus.o_dram_addr !== '0 ||
            bus.o_dram_data_o !== '0) begin
            errors++;
            $display("FAIL reset_in_fill: got rdy %b rv %b wv %b fr %b addr %h expected 1 0 0 0 0",
                     bus.o_type_ready, bus.o_data_o_valid, bus.o_dram_data_o_valid,
                     bus.o_dram_data_i_ready, bus.o_dram_addr);
        end
        nreset = 1'b1;
        model_reset();
        txn(T_READ, 64'h100, rand128(), rand128(), 0, 0);
        txn(T_READ, 64'h200, rand128(), rand128(), 0, 0);
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_nop();
        test_resp_stall();
        test_write_evict();
        test_fetch_priority();
        test_consume();
        test_random();
        test_reset_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
